// File: rtl/freq_table_scanner.sv
// Scans a symbol-count table, accumulating total and distinct-symbol counts while
// streaming (symbol, count) pairs downstream. Define FREQ_SCAN_SKIP_ZERO_EN to skip zero-count entries.
module freq_table_scanner #(
    parameter int TABLE_SIZE  = 256,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    output logic [7:0]               rd_addr_out,
    input  logic [COUNT_WIDTH-1:0]   rd_data_in,
    output logic [7:0]               sym_out,
    output logic [COUNT_WIDTH-1:0]   cnt_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic [8:0]               distinct_out,
    output logic [COUNT_WIDTH+7:0]   total_out
);

    localparam logic [7:0] LAST_ADDR = 8'(TABLE_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CHECK = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state, state_next;
    logic [7:0] addr;
    logic       last_entry;
    logic       select_entry;
    logic       addr_clear;
    logic       addr_incr;
    logic       emit_load;
    logic       emit_ack;
    logic       acc_en;

    assign last_entry  = (addr == LAST_ADDR);
    assign rd_addr_out = addr;
    assign busy_out    = (state == FETCH) || (state == CHECK) || (state == EMIT);
    assign done_out    = (state == DONE);

`ifdef FREQ_SCAN_SKIP_ZERO_EN
    assign select_entry = (rd_data_in != '0);
`else
    assign select_entry = 1'b1;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_clear = 1'b0;
        addr_incr  = 1'b0;
        emit_load  = 1'b0;
        emit_ack   = 1'b0;
        acc_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    addr_clear = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = CHECK;
            end
            CHECK: begin
                acc_en = 1'b1;
                if (select_entry) begin
                    emit_load  = 1'b1;
                    state_next = EMIT;
                end else if (last_entry) begin
                    state_next = DONE;
                end else begin
                    addr_incr  = 1'b1;
                    state_next = FETCH;
                end
            end
            EMIT: begin
                // Output registers stay frozen until the downstream handshake.
                if (valid_out && ready_in) begin
                    emit_ack = 1'b1;
                    if (last_entry) begin
                        state_next = DONE;
                    end else begin
                        addr_incr  = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr         <= '0;
            distinct_out <= '0;
            total_out    <= '0;
        end else begin
            if (addr_clear) begin
                addr         <= '0;
                distinct_out <= '0;
                total_out    <= '0;
            end else begin
                if (addr_incr) begin
                    addr <= addr + 8'd1;
                end
                // Totals are widened so a full table of maximum counts cannot wrap.
                if (acc_en) begin
                    total_out <= total_out + {8'd0, rd_data_in};
                    if (rd_data_in != '0) begin
                        distinct_out <= distinct_out + 9'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_out <= 1'b0;
            sym_out   <= '0;
            cnt_out   <= '0;
        end else begin
            if (emit_load) begin
                valid_out <= 1'b1;
                sym_out   <= addr;
                cnt_out   <= rd_data_in;
            end else if (emit_ack) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_table_scanner.sv
// Directed bench for freq_table_scanner: a table memory, a queue-based model of the
// expected emissions/totals, and a per-cycle compare process.
module tb_freq_table_scanner;

`ifdef FREQ_SCAN_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data = '0;
    logic [7:0]  sym;
    logic [7:0]  cnt;
    logic        valid;
    logic        busy;
    logic        done;
    logic [8:0]  distinct;
    logic [15:0] total;

    logic [7:0] mem [256];

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] c;
    } emit_t;

    emit_t exp_q[$];
    int    vecs = 0;
    int    errs = 0;
    int    exp_dist;
    int    exp_tot;
    int    emit_cnt;
    int    stalls;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_sym, prev_cnt, prev_addr;

    freq_table_scanner #(.TABLE_SIZE(256), .COUNT_WIDTH(8)) dut (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .start_in    (start),
        .rd_addr_out (rd_addr),
        .rd_data_in  (rd_data),
        .sym_out     (sym),
        .cnt_out     (cnt),
        .valid_out   (valid),
        .ready_in    (ready),
        .busy_out    (busy),
        .done_out    (done),
        .distinct_out(distinct),
        .total_out   (total)
    );

    always #5 clk = ~clk;

    // Synchronous table: data for an address appears one cycle later.
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_model();
        exp_q.delete();
        exp_dist = 0;
        exp_tot  = 0;
        emit_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] != 0) exp_dist++;
            exp_tot += int'(mem[i]);
            if (!SKIP || mem[i] != 0) exp_q.push_back({8'(i), mem[i]});
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(valid), 1);
                check("hold_sym", 32'(sym), 32'(prev_sym));
                check("hold_cnt", 32'(cnt), 32'(prev_cnt));
                check("hold_addr", 32'(rd_addr), 32'(prev_addr));
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_emit", 32'(sym), 32'hFFFF_FFFF);
                end else begin
                    emit_t e;
                    e = exp_q.pop_front();
                    check("emit_sym", 32'(sym), 32'(e.s));
                    check("emit_cnt", 32'(cnt), 32'(e.c));
                end
                emit_cnt++;
            end
            prev_stall = valid && !ready;
            prev_sym   = sym;
            prev_cnt   = cnt;
            prev_addr  = rd_addr;
            if (done) begin
                check("done_queue_left", 32'(exp_q.size()), 0);
                check("done_distinct", 32'(distinct), 32'(exp_dist));
                check("done_total", 32'(total), 32'(exp_tot));
            end
        end
    end

    // mode 0: ready always 1; mode 1: stall 10 cycles on the (3,5) emission;
    // mode 2: pulse start in the middle of the scan.
    task automatic run_scan(input int mode, input int exp_emits, input int exp_lat);
        int cycles;
        build_model();
        stalls = 0;
        ready  = 1'b1;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 0;
        check("busy_after_start", 32'(busy), 1);
        while (!done && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
            if (mode == 2) start = (cycles == 50);
            if (mode == 1) begin
                ready = !(valid && sym == 8'd3 && stalls < 10);
                if (!ready) begin
                    stalls++;
                    check("stall_sym", 32'(sym), 3);
                    check("stall_cnt", 32'(cnt), 5);
                    check("stall_addr", 32'(rd_addr), 3);
                end
            end
        end
        start = 1'b0;
        ready = 1'b1;
        check("scan_finished", 32'(done), 1);
        if (exp_lat >= 0) check("done_latency", 32'(cycles), 32'(exp_lat));
        if (mode == 1) check("stall_cycles", 32'(stalls), 10);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 0);
        check("busy_after_done", 32'(busy), 0);
        check("emit_count", 32'(emit_cnt), 32'(exp_emits));
        repeat (3) @(posedge clk);
        #1;
        check("hold_distinct", 32'(distinct), 32'(exp_dist));
        check("hold_total", 32'(total), 32'(exp_tot));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        #1;
        check("rst_addr", 32'(rd_addr), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_distinct", 32'(distinct), 0);
        check("rst_total", 32'(total), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All-zero table: 2 cycles/entry when skipping, 3 when every entry is emitted.
        run_scan(0, SKIP ? 0 : 256, SKIP ? 512 : 768);
        check("zero_distinct", 32'(distinct), 0);
        check("zero_total", 32'(total), 0);

        // Two populated entries.
        mem[3] = 8'd5;
        mem[200] = 8'd255;
        run_scan(0, SKIP ? 2 : 256, -1);
        check("two_distinct", 32'(distinct), 2);
        check("two_total", 32'(total), 260);

        // Same table with a 10-cycle stall on the (3,5) emission.
        run_scan(1, SKIP ? 2 : 256, -1);
        check("stall_total", 32'(total), 260);

        // Full table of maximum counts.
        for (int i = 0; i < 256; i++) mem[i] = 8'd255;
        run_scan(0, 256, -1);
        check("full_distinct", 32'(distinct), 256);
        check("full_total", 32'(total), 65280);

        // Mixed table with a stray start pulse mid-scan.
        for (int i = 0; i < 256; i++) mem[i] = (i % 3 == 0) ? 8'd0 : 8'(i);
        run_scan(2, SKIP ? 170 : 256, -1);
        check("mixed_distinct", 32'(distinct), 170);

        // Reset in the middle of a full-table scan.
        for (int i = 0; i < 256; i++) mem[i] = 8'd255;
        build_model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_addr", 32'(rd_addr), 0);
        check("abort_sym", 32'(sym), 0);
        check("abort_cnt", 32'(cnt), 0);
        check("abort_valid", 32'(valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_distinct", 32'(distinct), 0);
        check("abort_total", 32'(total), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post_reset_done", 32'(done), 0);
            check("post_reset_busy", 32'(busy), 0);
        end
        run_scan(0, 256, -1);
        check("rerun_distinct", 32'(distinct), 256);
        check("rerun_total", 32'(total), 65280);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/freq_table_scanner.md
FREQ_TABLE_SCANNER -- requirements
Module: freq_table_scanner

Interface
REQ-001 The block SHALL have parameter TABLE_SIZE, default 256, giving the number of table entries (symbols 0..TABLE_SIZE-1).
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 8, giving the width of each table count.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start_in, input, 1 bit: single-cycle request to begin a scan.
REQ-006 The block SHALL have port rd_addr_out, output, 8 bits: table read address.
REQ-007 The block SHALL have port rd_data_in, input, COUNT_WIDTH bits: table count, valid one cycle after rd_addr_out.
REQ-008 The block SHALL have port sym_out, output, 8 bits: emitted symbol.
REQ-009 The block SHALL have port cnt_out, output, COUNT_WIDTH bits: emitted count.
REQ-010 The block SHALL have port valid_out, output, 1 bit: sym_out/cnt_out valid.
REQ-011 The block SHALL have port ready_in, input, 1 bit: downstream accepts.
REQ-012 The block SHALL have port busy_out, output, 1 bit: scan in progress.
REQ-013 The block SHALL have port done_out, output, 1 bit: one-cycle end-of-scan pulse.
REQ-014 The block SHALL have port distinct_out, output, 9 bits: number of nonzero entries.
REQ-015 The block SHALL have port total_out, output, COUNT_WIDTH+8 bits: sum of all counts.

Function
REQ-016 The block SHALL implement FSM states IDLE, FETCH, CHECK, EMIT and DONE.
REQ-017 In IDLE, start_in=1 SHALL clear the address, distinct_out and total_out, then enter FETCH with busy_out=1 on the next cycle.
REQ-018 In FETCH, the block SHALL drive rd_addr_out with the current address and enter CHECK on the next cycle.
REQ-019 In CHECK, the block SHALL sample rd_data_in, add it to total_out, and increment distinct_out when it is nonzero.
REQ-020 A CHECK entry selected for output SHALL register sym_out=address and cnt_out=rd_data_in, and the block SHALL enter EMIT with valid_out=1.
REQ-021 In EMIT, the block SHALL hold valid_out, sym_out and cnt_out stable until valid_out and ready_in are both 1 in the same cycle, for unbounded stall.
REQ-022 After a handshake, or after a CHECK entry not selected for output, the block SHALL enter DONE if address==TABLE_SIZE-1, else increment the address and enter FETCH.
REQ-023 ready_in=1 while valid_out=0 SHALL have no effect.
REQ-024 In DONE, done_out SHALL be 1 for exactly one cycle, busy_out SHALL drop, and the block SHALL return to IDLE.
REQ-025 distinct_out and total_out SHALL hold their final values from the DONE cycle until the next accepted start_in.
REQ-026 start_in SHALL be ignored in every state except IDLE.
REQ-027 Arithmetic SHALL NOT overflow: total_out is sized for TABLE_SIZE*(2^COUNT_WIDTH-1), and distinct_out reaches 256.
REQ-028 Minimum throughput SHALL be one entry per 2 cycles: FETCH plus CHECK, plus EMIT cycles when the entry is output.

Reset
REQ-029 While rst_in=0, the block SHALL asynchronously enter IDLE with every output 0 (rd_addr_out, sym_out, cnt_out, valid_out, busy_out, done_out, distinct_out, total_out).
REQ-030 Reset asserted mid-scan SHALL abort the scan with no done_out pulse, and the block SHALL require a new start_in after rst_in returns to 1.

Configuration
REQ-031 With macro FREQ_SCAN_SKIP_ZERO_EN defined, CHECK SHALL select only nonzero entries for EMIT, and zero entries SHALL go straight to the next address.
REQ-032 Without FREQ_SCAN_SKIP_ZERO_EN, every entry, including zero counts, SHALL be emitted in ascending symbol order; distinct_out and total_out SHALL behave identically in both builds.

Verification
REQ-033 Table all zero, skip enabled, ready_in=1, start -> no valid_out, done_out after 512 cycles, distinct_out=0, total_out=0.
REQ-034 Counts sym 3=5, sym 200=255, ready_in=1, skip enabled -> emits (3,5) then (200,255), distinct_out=2, total_out=260.
REQ-035 All 256 entries=255, skip disabled -> 256 emissions in order 0..255, distinct_out=256, total_out=65280.
REQ-036 ready_in held 0 for 10 cycles during an EMIT of (3,5) -> sym_out=3 and cnt_out=5 stable, and no address advance until ready_in=1.
REQ-037 start_in pulsed mid-scan -> ignored, with the scan result unchanged.
REQ-038 rst_in=0 mid-scan -> all outputs 0 immediately, no done_out pulse, and a rerun after restart gives correct totals.
